// File: rtl/intr_ctrl_if.sv
// Interrupt controller bus bundle: device interrupt lines, the CPU
// intr/inta pair and the memory-mapped register port.
//   irq   : raw device interrupt lines (asynchronous to clk)
//   intr  : interrupt request to the CPU
//   inta  : CPU acknowledge
//   addr  : CPU data address
//   wdata : CPU store data
//   we    : CPU store strobe
//   rdata : register read data
// master = CPU/device side, slave = controller side.
interface intr_ctrl_if #(
  parameter int NSRC = 8
) ();
  logic [NSRC-1:0] irq;
  logic            intr;
  logic            inta;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            we;
  logic [31:0]     rdata;

  modport master (output irq, inta, addr, wdata, we, input intr, rdata);
  modport slave  (input irq, inta, addr, wdata, we, output intr, rdata);
endinterface

// File: rtl/intr_ctrl.sv
// Programmable interrupt controller for the single-cycle MIPS core.
// Synchronises NSRC interrupt lines, tracks edge/level pending bits,
// masks and priority-resolves them (source 0 highest), raises intr and
// holds the acknowledged source in service until software writes EOI.
// Ports:
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset
//   bus : intr_ctrl_if.slave (irq, intr, inta, addr, wdata, we, rdata)
// Register window (32 bytes at BASE_ADDR):
//   0x00 MASK (RW), 0x04 EDGE (RW), 0x08 PEND (RO, W1C for edge bits),
//   0x0C VEC (RO: [31] valid, [30] spurious, [IDW-1:0] id), 0x10 EOI (WO).
module intr_ctrl #(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          IDW       = 4
) (
  input  logic       clk,
  input  logic       clr,
  intr_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, emode_q, emode_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            valid_q, valid_d, spur_q, spur_d;

  logic            hit;
  logic [2:0]      offset;
  logic            wr_mask, wr_emode, wr_pend, wr_eoi;
  logic [NSRC-1:0] rise, active, win_onehot, pend_clr;
  logic [IDW-1:0]  win_id;
  logic            accept;
  logic [31:0]     vec_c, rdata_c;
  logic            unused_bits;

  assign unused_bits = ^{bus.wdata[31:NSRC], bus.addr[1:0]};

  // Address decode
  always_comb begin
    hit      = (bus.addr[31:5] == BASE_ADDR[31:5]);
    offset   = bus.addr[4:2];
    wr_mask  = bus.we && hit && (offset == 3'd0);
    wr_emode = bus.we && hit && (offset == 3'd1);
    wr_pend  = bus.we && hit && (offset == 3'd2);
    wr_eoi   = bus.we && hit && (offset == 3'd4);
  end

  // Synchroniser and pending bits
  always_comb begin
    s1_d = bus.irq;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    active = pend_q & mask_q;
    // Isolate the lowest set bit: that is the highest-priority source.
    win_onehot = active & (~active + NSRC'(1));
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = IDW'(i);
    end
    accept   = (state_q == REQ) && bus.inta;
    pend_clr = (wr_pend ? bus.wdata[NSRC-1:0] : '0) | (accept ? win_onehot : '0);
    // Edge bits: a rise in the same cycle as a clear keeps the bit set.
    // Level bits simply track the synchronised line.
    pend_d  = (emode_q & ((pend_q & ~pend_clr) | rise)) | (~emode_q & s2_q);
    mask_d  = wr_mask  ? bus.wdata[NSRC-1:0] : mask_q;
    emode_d = wr_emode ? bus.wdata[NSRC-1:0] : emode_q;
  end

  // Request / service FSM
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    valid_d = valid_q;
    spur_d  = spur_q;
    unique case (state_q)
      IDLE: if (|active) state_d = REQ;
      REQ: begin
        if (bus.inta) begin
          state_d = SERV;
          valid_d = 1'b1;
          // Acknowledge with nothing left active: report a spurious vector.
          spur_d  = ~|active;
          id_d    = (|active) ? win_id : '0;
        end else if (!(|active)) begin
          state_d = IDLE;
        end
      end
      SERV: begin
        if (wr_eoi) begin
          state_d = IDLE;
          valid_d = 1'b0;
          spur_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register read mux
  always_comb begin
    vec_c          = '0;
    vec_c[31]      = valid_q;
    vec_c[30]      = spur_q;
    vec_c[IDW-1:0] = id_q;
    rdata_c        = '0;
    if (hit) begin
      case (offset)
        3'd0:    rdata_c = 32'(mask_q);
        3'd1:    rdata_c = 32'(emode_q);
        3'd2:    rdata_c = 32'(pend_q);
        3'd3:    rdata_c = vec_c;
        default: rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.intr  = (state_q == REQ);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      emode_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      emode_q <= emode_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      spur_q  <= spur_d;
    end
  end
endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  localparam int          NSRC   = 8;
  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_MASK = BASE;
  localparam logic [31:0] A_EDGE = BASE + 32'h04;
  localparam logic [31:0] A_PEND = BASE + 32'h08;
  localparam logic [31:0] A_VEC  = BASE + 32'h0C;
  localparam logic [31:0] A_EOI  = BASE + 32'h10;

  logic clk = 1'b0;
  logic clr;

  intr_ctrl_if #(.NSRC(NSRC)) bus();

  intr_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE), .IDW(4)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_mask, m_edge, m_pend;
  logic [7:0] m_seen[$];   // irq samples, oldest first; last three edges
  int         m_phase;     // 0 idle, 1 requesting, 2 in service
  int         m_id;
  bit         m_valid, m_spur;

  function automatic void m_reset();
    m_mask = '0; m_edge = '0; m_pend = '0;
    m_phase = 0; m_id = 0; m_valid = 1'b0; m_spur = 1'b0;
    m_seen = {};
    for (int i = 0; i < 3; i++) m_seen.push_back(8'h00);
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    v = '0;
    v[31] = m_valid;
    v[30] = m_spur;
    v[3:0] = 4'(m_id);
    return v;
  endfunction

  function automatic void m_step(input logic [7:0] irq_in, input bit ack, input bit w,
                                 input logic [31:0] a, input logic [31:0] d);
    logic [7:0] s2, s3, act, np;
    int win, off;
    bit hit, w1c, eoi, took;
    s2 = m_seen[1];
    s3 = m_seen[0];
    act = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < NSRC; i++) if (act[i] && win < 0) win = i;
    hit = w && (a[31:5] == BASE[31:5]);
    off = int'(a[4:2]);
    w1c = hit && off == 2;
    eoi = hit && off == 4;
    took = (m_phase == 1) && ack;
    np = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_edge[i]) begin
        if (s2[i] && !s3[i]) np[i] = 1'b1;
        else if ((w1c && d[i]) || (took && win == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = s2[i];
      end
    end
    case (m_phase)
      0: if (act != 0) m_phase = 1;
      1: begin
        if (ack) begin
          m_phase = 2;
          m_valid = 1'b1;
          m_spur  = (win < 0);
          m_id    = (win < 0) ? 0 : win;
        end else if (act == 0) begin
          m_phase = 0;
        end
      end
      default: if (eoi) begin m_phase = 0; m_valid = 1'b0; m_spur = 1'b0; end
    endcase
    if (hit && off == 0) m_mask = d[7:0];
    if (hit && off == 1) m_edge = d[7:0];
    m_pend = np;
    m_seen.push_back(irq_in);
    void'(m_seen.pop_front());
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    check(name, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    d = bus.rdata;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic ack();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    bit          we;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  r_irq;
    bit          r_ack, r_we;
    logic [31:0] r_addr, r_wd;

    tbl[0]  = '{A_MASK, 32'hFFFF_FFA5, 1'b1, A_MASK, 32'h0000_00A5};
    tbl[1]  = '{A_EDGE, 32'h0000_0133, 1'b1, A_EDGE, 32'h0000_0033};
    tbl[2]  = '{A_PEND, 32'h0000_00FF, 1'b1, A_PEND, 32'h0};
    tbl[3]  = '{A_VEC,  32'hFFFF_FFFF, 1'b1, A_VEC,  32'h0};
    tbl[4]  = '{A_EOI,  32'hFFFF_FFFF, 1'b1, A_EOI,  32'h0};
    tbl[5]  = '{BASE + 32'h14, 32'hFFFF_FFFF, 1'b1, BASE + 32'h14, 32'h0};
    tbl[6]  = '{BASE + 32'h14, 32'h0, 1'b0, A_EDGE, 32'h0000_0033};
    tbl[7]  = '{BASE + 32'h1C, 32'hFFFF_FFFF, 1'b1, BASE + 32'h1C, 32'h0};
    tbl[8]  = '{BASE + 32'h18, 32'hFFFF_FFFF, 1'b1, A_MASK, 32'h0000_00A5};
    tbl[9]  = '{BASE + 32'h20, 32'h0000_000F, 1'b1, BASE + 32'h20, 32'h0};
    tbl[10] = '{BASE + 32'h20, 32'h0, 1'b0, A_MASK, 32'h0000_00A5};
    tbl[11] = '{BASE - 32'h20, 32'h0, 1'b1, A_MASK, 32'h0000_00A5};
    tbl[12] = '{A_MASK, 32'h0, 1'b1, A_MASK, 32'h0};
    tbl[13] = '{A_EDGE, 32'h0, 1'b1, A_EDGE, 32'h0};

    clr = 1'b1;
    bus.irq = '0; bus.inta = 1'b0; bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check_b("rst_intr", bus.intr, 1'b0);
    clr = 1'b0;
    tick();
    chk_rd("rst_mask", A_MASK, 32'h0);
    chk_rd("rst_edge", A_EDGE, 32'h0);
    chk_rd("rst_pend", A_PEND, 32'h0);
    chk_rd("rst_vec",  A_VEC,  32'h0);
    bus.irq = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_b("masked_intr", bus.intr, 1'b0);
    end
    bus.irq = '0;
    tick(); tick(); tick(); tick();

    // Register access table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) wr(tbl[i].waddr, tbl[i].wdata);
      chk_rd($sformatf("reg_tbl_%0d", i), tbl[i].raddr, tbl[i].exp);
      check_b($sformatf("reg_tbl_intr_%0d", i), bus.intr, 1'b0);
    end

    // Single edge source
    wr(A_MASK, 32'h08);
    wr(A_EDGE, 32'h08);
    bus.irq = 8'h08; tick(); bus.irq = '0;
    check_b("edge_e0", bus.intr, 1'b0);
    tick(); check_b("edge_e1", bus.intr, 1'b0);
    tick(); check_b("edge_e2", bus.intr, 1'b0);
    chk_rd("edge_pend", A_PEND, 32'h08);
    tick(); check_b("edge_e3", bus.intr, 1'b1);
    ack();
    check_b("edge_ack_intr", bus.intr, 1'b0);
    chk_rd("edge_vec", A_VEC, 32'h8000_0003);
    chk_rd("edge_pend_clr", A_PEND, 32'h0);
    wr(A_EOI, 32'h0);
    chk_rd("edge_eoi_vec", A_VEC, 32'h0000_0003);
    tick(); check_b("edge_idle", bus.intr, 1'b0);

    // Priority
    wr(A_MASK, 32'hFF);
    wr(A_EDGE, 32'hFF);
    bus.irq = 8'h24; tick(); bus.irq = '0;
    tick(); tick(); tick();
    check_b("prio_intr", bus.intr, 1'b1);
    ack();
    chk_rd("prio_vec1", A_VEC, 32'h8000_0002);
    chk_rd("prio_pend1", A_PEND, 32'h20);
    wr(A_EOI, 32'h0);
    check_b("prio_eoi_intr", bus.intr, 1'b0);
    tick(); check_b("prio_reassert", bus.intr, 1'b1);
    ack();
    chk_rd("prio_vec2", A_VEC, 32'h8000_0005);
    wr(A_EOI, 32'h0);
    chk_rd("prio_pend2", A_PEND, 32'h0);

    // Level source
    wr(A_EDGE, 32'h00);
    wr(A_MASK, 32'h01);
    bus.irq = 8'h01;
    tick(); tick(); tick(); tick();
    check_b("lvl_intr", bus.intr, 1'b1);
    ack();
    chk_rd("lvl_vec", A_VEC, 32'h8000_0000);
    chk_rd("lvl_pend", A_PEND, 32'h01);
    tick(); tick();
    check_b("lvl_serv_block", bus.intr, 1'b0);
    wr(A_EOI, 32'h0);
    check_b("lvl_eoi_intr", bus.intr, 1'b0);
    tick(); check_b("lvl_reassert", bus.intr, 1'b1);
    ack();
    bus.irq = '0;
    tick(); tick(); tick();
    chk_rd("lvl_pend_drop", A_PEND, 32'h0);
    wr(A_EOI, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_b("lvl_stay_low", bus.intr, 1'b0);
      tick();
    end

    // Spurious acknowledge
    wr(A_MASK, 32'h02);
    bus.irq = 8'h02;
    tick(); tick(); tick(); tick();
    check_b("spur_intr", bus.intr, 1'b1);
    bus.irq = '0;
    tick(); tick(); tick();
    check_b("spur_still_req", bus.intr, 1'b1);
    chk_rd("spur_pend", A_PEND, 32'h0);
    ack();
    chk_rd("spur_vec", A_VEC, 32'hC000_0000);
    check_b("spur_ack_intr", bus.intr, 1'b0);
    wr(A_EOI, 32'h0);
    chk_rd("spur_eoi_vec", A_VEC, 32'h0);

    // Mid-service reset
    wr(A_MASK, 32'h08);
    wr(A_EDGE, 32'h08);
    bus.irq = 8'h08; tick(); bus.irq = '0;
    tick(); tick(); tick();
    ack();
    chk_rd("mid_vec_pre", A_VEC, 32'h8000_0003);
    clr = 1'b1;
    #1;
    chk_rd("mid_vec_rst", A_VEC, 32'h0);
    check_b("mid_intr_rst", bus.intr, 1'b0);
    chk_rd("mid_mask_rst", A_MASK, 32'h0);
    tick();
    clr = 1'b0;
    tick();

    // Set/clear collision on an edge bit
    wr(A_EDGE, 32'h10);
    bus.irq = 8'h10;
    tick(); tick();
    wr(A_PEND, 32'h10);
    chk_rd("coll_set_wins", A_PEND, 32'h10);
    wr(A_PEND, 32'h10);
    chk_rd("coll_w1c", A_PEND, 32'h0);
    bus.irq = '0;

    // Randomized run against the reference model
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_reset();
    tick();
    m_step(8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 1500; c++) begin
      check_b("rnd_intr", bus.intr, m_phase == 1);
      rd(A_VEC, d);  check("rnd_vec", d, m_vec());
      rd(A_PEND, d); check("rnd_pend", d, {24'b0, m_pend});
      r_irq  = bus.irq ^ 8'($urandom & $urandom & $urandom);
      r_ack  = ($urandom_range(0, 3) == 0);
      r_we   = ($urandom_range(0, 3) == 0);
      r_addr = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      r_wd   = $urandom;
      bus.irq = r_irq; bus.inta = r_ack; bus.we = r_we;
      bus.addr = r_addr; bus.wdata = r_wd;
      @(posedge clk);
      m_step(r_irq, r_ack, r_we, r_addr, r_wd);
      #1;
    end
    bus.we = 1'b0;
    bus.inta = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
